// File: rtl/sample_ser_pkg.sv
// Shared types, line levels and frame-length helper for the sample serial transmitter.
package sample_ser_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} ser_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Cycles from the first start-bit cycle through the last stop-bit cycle.
    function automatic int unsigned frame_cycles(input int unsigned width,
                                                 input int unsigned div,
                                                 input int unsigned parity_en);
        return (width + 2 + parity_en) * div;
    endfunction

endpackage

// File: rtl/sample_ser_tx_if.sv
// Parallel word handshake into the serial transmitter.
interface sample_ser_tx_if #(parameter int unsigned WIDTH = 4);

    logic [WIDTH-1:0] pi_data;
    logic             pi_valid;
    logic             pi_ready;

    modport master (output pi_data, output pi_valid, input pi_ready);
    modport slave  (input pi_data, input pi_valid, output pi_ready);

endinterface

// File: rtl/sample_ser_baud.sv
// Bit-period divider: tick pulses on the last cycle of every DIV-cycle bit period.
module sample_ser_baud #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned    CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/sample_ser_tx.sv
// Parallel-to-serial frame transmitter: start, WIDTH data bits LSB-first,
// optional even parity, stop. Line and its complement are registered.
module sample_ser_tx
    import sample_ser_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DIV       = 2,
    parameter int unsigned PARITY_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    sample_ser_tx_if.slave     pi,
    output logic               so_data,
    output logic               so_data_n,
    output logic               busy
);

    localparam int unsigned   BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             par_q, par_d;
    logic             line_d;
    logic             tick;
    logic             baud_clear;

    // Divider holds at zero while idle and restarts on every state change.
    assign baud_clear = (state_q == IDLE) || (state_d != state_q);

    sample_ser_baud #(.DIV(DIV)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (baud_clear),
        .tick  (tick)
    );

    assign pi.pi_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_q     <= '0;
            par_q     <= 1'b0;
            so_data   <= IDLE_LEVEL;
            so_data_n <= ~IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            par_q     <= par_d;
            so_data   <= line_d;
            so_data_n <= ~line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        par_d   = par_q;
        line_d  = IDLE_LEVEL;

        unique case (state_q)
            IDLE: begin
                if (pi.pi_valid) begin
                    state_d = START;
                    shift_d = pi.pi_data;
                    par_d   = ^pi.pi_data;
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) bit_d = '0;

        // Line is registered from the next state so it changes exactly on bit boundaries.
        unique case (state_d)
            START:   line_d = START_LEVEL;
            DATA:    line_d = shift_d[0];
            PARITY:  line_d = par_d;
            STOP:    line_d = STOP_LEVEL;
            default: line_d = IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_sample_ser_tx.sv
// Randomized self-checking bench for sample_ser_tx (two parameterisations).
module tb_sample_ser_tx;

    logic clk;
    logic rst_n;
    logic so_a, son_a, busy_a;
    logic so_b, son_b, busy_b;
    int   total;
    int   bad;

    localparam int F_A = (4 + 2 + 1) * 2;
    localparam int F_B = (4 + 2 + 0) * 1;

    sample_ser_tx_if #(.WIDTH(4)) if_a ();
    sample_ser_tx_if #(.WIDTH(4)) if_b ();

    sample_ser_tx #(.WIDTH(4), .DIV(2), .PARITY_EN(1)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .pi        (if_a.slave),
        .so_data   (so_a),
        .so_data_n (son_a),
        .busy      (busy_a)
    );

    sample_ser_tx #(.WIDTH(4), .DIV(1), .PARITY_EN(0)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .pi        (if_b.slave),
        .so_data   (so_b),
        .so_data_n (son_b),
        .busy      (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level in frame cycle k (1-based after the accept edge).
    function automatic logic exp_line(input logic [3:0] w, input int div,
                                      input int pen, input int k);
        int idx;
        idx = (k - 1) / div;
        if (idx == 0) return 1'b0;
        if (idx <= 4) return w[idx-1];
        if (pen != 0 && idx == 5) return ($countones(w) % 2) == 1;
        return 1'b1;
    endfunction

    task automatic test_reset();
        logic [3:0] w;
        w = 4'($urandom);
        rst_n = 1'b0;
        if_a.pi_valid = 1'b1; if_a.pi_data = w;
        if_b.pi_valid = 1'b1; if_b.pi_data = 4'($urandom);
        repeat (3) @(negedge clk);
        total++;
        if ({so_a, son_a, busy_a, if_a.pi_ready} !== 4'b1001) begin
            bad++;
            $display("FAIL reset_a so/so_n/busy/ready got %b want 1001",
                     {so_a, son_a, busy_a, if_a.pi_ready});
        end
        total++;
        if ({so_b, son_b, busy_b, if_b.pi_ready} !== 4'b1001) begin
            bad++;
            $display("FAIL reset_b so/so_n/busy/ready got %b want 1001",
                     {so_b, son_b, busy_b, if_b.pi_ready});
        end
        if_b.pi_valid = 1'b0;
        rst_n = 1'b1;
        test_frame(w, 1'b0);
    endtask

    // Sends w on dut_a (accept on the next rising edge) and checks the whole frame.
    task automatic test_frame(input logic [3:0] w, input bit perturb);
        int guard;
        guard = 0;
        while (!if_a.pi_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (!if_a.pi_ready) begin
            bad++;
            $display("FAIL idle_wait ready got %b want 1", if_a.pi_ready);
        end
        if_a.pi_data  = w;
        if_a.pi_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= F_A + 1; k++) begin
            @(negedge clk);
            if (k == 1) if_a.pi_valid = 1'b0;
            if (k <= F_A) begin
                total++;
                if (so_a !== exp_line(w, 2, 1, k) || son_a !== ~so_a) begin
                    bad++;
                    $display("FAIL line_a w=%b k=%0d so=%b so_n=%b want so=%b", w, k,
                             so_a, son_a, exp_line(w, 2, 1, k));
                end
                total++;
                if (busy_a !== 1'b1 || if_a.pi_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_a k=%0d busy=%b ready=%b want 1/0", k, busy_a,
                             if_a.pi_ready);
                end
            end else begin
                total++;
                if ({so_a, son_a, busy_a, if_a.pi_ready} !== 4'b1001) begin
                    bad++;
                    $display("FAIL return_idle_a so/so_n/busy/ready got %b want 1001",
                             {so_a, son_a, busy_a, if_a.pi_ready});
                end
            end
            if (perturb && k == 3) begin
                if_a.pi_data  = ~w;
                if_a.pi_valid = 1'b1;
            end
            if (perturb && k == 4) if_a.pi_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic exp;
        if_b.pi_data  = 4'hF;
        if_b.pi_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 3 * (F_B + 1); k++) begin
            int pos;
            @(negedge clk);
            pos = (k - 1) % (F_B + 1);
            exp = (pos < F_B) ? exp_line(4'hF, 1, 0, pos + 1) : 1'b1;
            total++;
            if (so_b !== exp || son_b !== ~exp || if_b.pi_ready !== (pos == F_B)) begin
                bad++;
                $display("FAIL b2b_b k=%0d so=%b so_n=%b ready=%b want so=%b ready=%b",
                         k, so_b, son_b, if_b.pi_ready, exp, pos == F_B);
            end
        end
        if_b.pi_valid = 1'b0;
        repeat (F_B + 2) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic [3:0] w;
        w = 4'($urandom) & 4'b1101;
        if_a.pi_data  = w;
        if_a.pi_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if_a.pi_valid = 1'b0;
        end
        total++;
        if (so_a !== 1'b0) begin
            bad++;
            $display("FAIL pre_reset_line so got %b want 0", so_a);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({so_a, son_a, busy_a, if_a.pi_ready} !== 4'b1001) begin
            bad++;
            $display("FAIL async_reset so/so_n/busy/ready got %b want 1001",
                     {so_a, son_a, busy_a, if_a.pi_ready});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_frame(4'b0001, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        if_a.pi_valid = 1'b0; if_a.pi_data = '0;
        if_b.pi_valid = 1'b0; if_b.pi_data = '0;
        test_reset();
        test_frame(4'b1010, 1'b0);
        test_frame(4'b0111, 1'b0);
        repeat (6) test_frame(4'($urandom), 1'b0);
        repeat (2) test_frame(4'($urandom), 1'b1);
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
